// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush and operand forwarding
// control for the 5-stage pipeline. It tracks a shadow of the destination
// register state of the in-flight instructions and counts hazard events.
module hazard_ctrl #(
  parameter int AW          = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [AW-1:0]    id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Branch resolved in MEM also squashes the instruction sitting in EX/MEM.
  localparam bit DEEP_FLUSH = (FLUSH_DEPTH == 3);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dest;
    logic          reg_write;
    logic          mem_read;
  } entry_t;

  // Only the EX and MEM producers are ever consulted: a WB producer is
  // written to the register file before the same-cycle read, so its entry
  // carries no information once it leaves MEM and is not kept.
  entry_t ex_reg;
  entry_t mem_reg;
  entry_t dec_entry;

  logic       lu;
  logic       stall;
  logic       bubble;
  logic [1:0] fwd_a_next;
  logic [1:0] fwd_b_next;

  // Select for one operand: youngest valid writer of a nonzero register wins.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [AW-1:0] src,
                                         input entry_t ex_e, input entry_t mem_e);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses) begin
      if (ex_e.valid && ex_e.reg_write && (ex_e.dest != '0) && (ex_e.dest == src))
        sel = 2'b10;
      else if (mem_e.valid && mem_e.reg_write && (mem_e.dest != '0) && (mem_e.dest == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection: load in EX feeding the decode instruction, and the
  // forwarding selects the decode instruction will need once it reaches EX.
  always_comb begin
    dec_entry.valid     = id_valid;
    dec_entry.dest      = id_dest;
    dec_entry.reg_write = id_reg_write;
    dec_entry.mem_read  = id_mem_read;

    lu = id_valid && ex_reg.valid && ex_reg.mem_read && (ex_reg.dest != '0) &&
         ((id_uses_rs && (id_rs == ex_reg.dest)) || (id_uses_rt && (id_rt == ex_reg.dest)));
    // A squashed instruction never stalls, so the branch wins.
    stall  = lu && !br_taken;
    bubble = stall || br_taken;

    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (id_valid && !bubble) begin
      fwd_a_next = fwd_sel(id_uses_rs, id_rs, ex_reg, mem_reg);
      fwd_b_next = fwd_sel(id_uses_rt, id_rt, ex_reg, mem_reg);
    end
  end

  // Pipeline register enables and flushes; reset forces the free-running state.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!reset) begin
      if (br_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = DEEP_FLUSH;
      end else if (lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Shadow state shift, registered forwarding selects and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_reg    <= '0;
      mem_reg   <= '0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_reg  <= bubble ? '0 : dec_entry;
      mem_reg <= (br_taken && DEEP_FLUSH) ? '0 : ex_reg;
      fwd_a   <= fwd_a_next;
      fwd_b   <= fwd_b_next;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
